// File: rtl/fifo_uart_tx.sv
// Pops bytes from the async FIFO read side and sends each one as a UART frame, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit and send 8E1 instead of 8N1.
module fifo_uart_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       r_clk,
  input  logic       rst,
  input  logic       r_empty,
  input  logic [7:0] r_data,
  output logic       r_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_last;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (!r_empty) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      // FIFO data arrives one cycle after the pop strobe
      LOAD: begin
        shift_d = r_data;
`ifdef UART_TX_PARITY_EN
        parity_d = ^r_data;
`endif
        state_d = START;
      end
      START: begin
        if (baud_last) begin
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) state_d = STOP;
        else           baud_d  = baud_q + CNT_W'(1);
      end
`endif
      // Chaining straight into POP keeps busy high and leaves only a 2-cycle gap
      STOP: begin
        if (baud_last) begin
          tx_done = 1'b1;
          state_d = r_empty ? IDLE : POP;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is chosen from the upcoming state so tx lines up with it and stays glitch-free
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign r_en = (state_q == POP);
  assign busy = (state_q != IDLE);
  assign tx   = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a FIFO model feeds the DUT and a frame-timing model predicts every output.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_fifo_uart_tx;

  localparam int C = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int F     = NBITS * C;
  localparam int LASTK = F + 1;

  logic       r_clk   = 1'b0;
  logic       rst     = 1'b1;
  logic       r_empty = 1'b1;
  logic [7:0] r_data  = 8'h00;
  logic       r_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(
    .CLK_FREQ(16),
    .BAUD(1)
  ) dut (
    .r_clk(r_clk),
    .rst(rst),
    .r_empty(r_empty),
    .r_data(r_data),
    .r_en(r_en),
    .tx(tx),
    .busy(busy),
    .tx_done(tx_done)
  );

  always #5 r_clk = ~r_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] m_q[$];
  logic [7:0] pending[$];
  bit         popped_last = 1'b0;

  // Model: a frame is an offset k counted from the pop cycle
  bit         m_active = 1'b0;
  int         m_k      = 0;
  logic [7:0] m_byte   = 8'h00;

  int   ren_at[$];
  int   done_at[$];
  int   start_at[$];
  logic tx_hist[$];
  logic busy_hist[$];
  bit   await_start = 1'b0;
  int   obs_base    = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  function automatic logic model_tx(input logic [7:0] b, input int k);
    int bit_i;
    if (k < 2) return 1'b1;
    bit_i = (k - 2) / C;
    if (bit_i == 0) return 1'b0;
    if (bit_i <= 8) return b[bit_i-1];
`ifdef UART_TX_PARITY_EN
    if (bit_i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic compareCycle();
    logic e_ren, e_busy, e_done, e_tx;
    e_ren  = m_active && (m_k == 0);
    e_busy = m_active;
    e_done = m_active && (m_k == LASTK);
    e_tx   = m_active ? model_tx(m_byte, m_k) : 1'b1;
    checkOutput("r_en", 32'(r_en), 32'(e_ren));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    checkOutput("tx_done", 32'(tx_done), 32'(e_done));
    checkOutput("tx", 32'(tx), 32'(e_tx));
  endtask

  task automatic clearObs();
    ren_at.delete();
    done_at.delete();
    start_at.delete();
    tx_hist.delete();
    busy_hist.delete();
    await_start = 1'b0;
    obs_base    = cyc + 1;
  endtask

  function automatic logic histTx(input int c);
    int i;
    i = c - obs_base;
    if (i < 0 || i >= tx_hist.size()) return 1'bx;
    return tx_hist[i];
  endfunction

  function automatic logic [7:0] decodeByte(input int s);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = histTx(s + C * (i + 1) + C / 2);
    return v;
  endfunction

  // One clock cycle: check outputs, serve the FIFO, set inputs for the next edge, advance the model
  task automatic applyStimulus(input bit rst_v);
    logic [7:0] b;
    @(negedge r_clk);
    cyc++;
    compareCycle();
    tx_hist.push_back(tx);
    busy_hist.push_back(busy);
    if (r_en === 1'b1) begin
      ren_at.push_back(cyc);
      await_start = 1'b1;
    end
    if (await_start && tx === 1'b0) begin
      start_at.push_back(cyc);
      await_start = 1'b0;
    end
    if (tx_done === 1'b1) done_at.push_back(cyc);

    if (r_en === 1'b1) begin
      checkOutput("pop_when_empty", 32'(fifo_q.size() == 0), 0);
      if (fifo_q.size() > 0) r_data = fifo_q.pop_front();
      popped_last = 1'b1;
    end else begin
      if (!popped_last) r_data = 8'($urandom);
      popped_last = 1'b0;
    end

    rst = rst_v;
    while (pending.size() > 0) begin
      b = pending.pop_front();
      fifo_q.push_back(b);
      m_q.push_back(b);
    end
    r_empty = (fifo_q.size() == 0);

    if (rst_v) begin
      m_active = 1'b0;
    end else if (!m_active || m_k == LASTK) begin
      if (!r_empty) begin
        m_active = 1'b1;
        m_k      = 0;
        m_byte   = (m_q.size() > 0) ? m_q.pop_front() : 8'h00;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_k++;
    end
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    while ((m_active || fifo_q.size() != 0) && n < bound) begin
      applyStimulus(1'b0);
      n++;
    end
    if (m_active || fifo_q.size() != 0) checkOutput("idle_timeout", 0, 1);
    applyStimulus(1'b0);
  endtask

  initial begin
    int t0, t1, tgt, n, nz;
    logic [7:0] b2b[3];
    b2b[0] = 8'h00;
    b2b[1] = 8'hFF;
    b2b[2] = 8'h55;
    $display("[TB] start, CLKS_PER_BIT=%0d, frame=%0d cycles", C, F);

    // Reset held with data waiting in the FIFO
    fifo_q.push_back(8'h5A);
    m_q.push_back(8'h5A);
    r_empty = 1'b0;
    clearObs();
    repeat (3) applyStimulus(1'b1);
    applyStimulus(1'b0);
    t0 = cyc;
    waitIdle(400);
    checkOutput("reset_ren_count", 32'(ren_at.size()), 1);
    if (ren_at.size() > 0) checkOutput("reset_first_ren_delay", 32'(ren_at[0] - t0), 1);

    // Single byte 0xA5
    repeat (5) applyStimulus(1'b0);
    clearObs();
    pending.push_back(8'hA5);
    applyStimulus(1'b0);
    t1 = cyc;
    waitIdle(400);
    repeat (2) applyStimulus(1'b0);
    checkOutput("single_ren_count", 32'(ren_at.size()), 1);
    checkOutput("single_done_count", 32'(done_at.size()), 1);
    if (start_at.size() > 0) begin
      checkOutput("single_start_latency", 32'(start_at[0] - t1), 3);
      checkOutput("single_data", 32'(decodeByte(start_at[0])), 32'h A5);
      if (done_at.size() > 0) checkOutput("single_done_offset", 32'(done_at[0] - start_at[0] + 1), 32'(F));
    end else begin
      checkOutput("single_start_seen", 0, 1);
    end

    // Back-to-back frames
    clearObs();
    for (int i = 0; i < 3; i++) pending.push_back(b2b[i]);
    applyStimulus(1'b0);
    waitIdle(1000);
    checkOutput("b2b_ren_count", 32'(ren_at.size()), 3);
    checkOutput("b2b_done_count", 32'(done_at.size()), 3);
    if (start_at.size() == 3 && done_at.size() == 3) begin
      for (int j = 0; j < 2; j++) checkOutput("b2b_gap", 32'(start_at[j+1] - done_at[j]), 3);
      for (int j = 0; j < 3; j++) checkOutput("b2b_data", 32'(decodeByte(start_at[j])), 32'(b2b[j]));
      nz = 0;
      for (int c = ren_at[0]; c <= done_at[2]; c++)
        if (busy_hist[c - obs_base] !== 1'b1) nz++;
      checkOutput("b2b_busy_gaps", 32'(nz), 0);
    end else begin
      checkOutput("b2b_frames_seen", 32'(start_at.size()), 3);
    end

    // Empty FIFO for 200 cycles
    clearObs();
    repeat (200) applyStimulus(1'b0);
    checkOutput("empty_ren_count", 32'(ren_at.size()), 0);
    nz = 0;
    for (int i = 0; i < busy_hist.size(); i++)
      if (busy_hist[i] !== 1'b0 || tx_hist[i] !== 1'b1) nz++;
    checkOutput("empty_line_activity", 32'(nz), 0);

    // Reset during data bit 3 of 0x3C
    clearObs();
    pending.push_back(8'h3C);
    applyStimulus(1'b0);
    n = 0;
    while (start_at.size() == 0 && n < 10) begin
      applyStimulus(1'b0);
      n++;
    end
    if (start_at.size() > 0) begin
      tgt = start_at[0] + 4 * C + C / 2;
      while (cyc < tgt) applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      checkOutput("midreset_tx", 32'(tx), 1);
      checkOutput("midreset_busy", 32'(busy), 0);
      repeat (60) applyStimulus(1'b0);
      checkOutput("midreset_ren_count", 32'(ren_at.size()), 1);
      checkOutput("midreset_done_count", 32'(done_at.size()), 0);
    end else begin
      checkOutput("midreset_start_seen", 0, 1);
    end

`ifdef UART_TX_PARITY_EN
    // Parity bit values and 11-bit frame length
    clearObs();
    pending.push_back(8'h07);
    pending.push_back(8'h03);
    applyStimulus(1'b0);
    waitIdle(1000);
    if (start_at.size() == 2 && done_at.size() == 2) begin
      checkOutput("parity_07", 32'(histTx(start_at[0] + 9 * C + C / 2)), 1);
      checkOutput("parity_03", 32'(histTx(start_at[1] + 9 * C + C / 2)), 0);
      checkOutput("parity_frame_len", 32'(done_at[0] - start_at[0] + 1), 176);
    end else begin
      checkOutput("parity_frames_seen", 32'(start_at.size()), 2);
    end
`endif

    // Random traffic with occasional resets
    clearObs();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0 && (fifo_q.size() + pending.size()) < 8)
        pending.push_back(8'($urandom));
      applyStimulus($urandom_range(0, 999) == 0);
    end
    waitIdle(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
